// File: rtl/multi_word_ctrl.sv
// multi_word_ctrl: decode FSM for the accumulator ISA; owns state and the two-word prefix; alu_op: 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 xora
module multi_word_ctrl #(
  parameter int IW  = 9,
  parameter int DW  = 8,
  parameter int PCW = 9
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [IW-1:0]  instr,
  input  logic           instr_valid,
  input  logic [2:0]     flags,
  output logic [2:0]     alu_op,
  output logic [1:0]     alu_src,
  output logic           acc_wr_en,
  output logic           reg_wr_en,
  output logic           acc_clr,
  output logic           reg_clr,
  output logic           cmp_load_en,
  output logic           lfsr_set_state,
  output logic           lfsr_set_tap,
  output logic           lfsr_shift,
  output logic           mem_addr_sel,
  output logic [DW-1:0]  mem_addr,
  output logic           mem_val_sel,
  output logic           mem_wr_en,
  output logic [DW-1:0]  imm,
  output logic           jump,
  output logic [PCW-1:0] jump_target,
  output logic           skip,
  output logic           busy,
  output logic           ack
);
  typedef enum logic [1:0] {REGULAR, TARGET, IMM, HALT} state_t;
  state_t state, state_n;
  logic pre_b, pre_b_n, pre_sel, pre_sel_n;
  logic [3:0] pre_op, pre_op_n, op, sub;
  logic [1:0] am;
  logic b, br_hit;
  logic [4:0] m, pm;
  function automatic logic [4:0] math(input logic [3:0] o);
    return o == 4'h1 ? 5'b10001 : o == 4'h2 ? 5'b10010 : o == 4'h3 ? 5'b11001 :
           o == 4'h5 ? 5'b10011 : o == 4'h6 ? 5'b10100 : o == 4'h7 ? 5'b10101 :
           o == 4'h8 ? 5'b10110 : 5'b00000;
  endfunction
  assign b   = instr[IW-1];
  assign op  = instr[IW-2 -: 4];
  assign sub = instr[3:0];
  assign am  = sub[3:2];
  assign m   = math(op);
  assign pm  = math(pre_op);
  assign br_hit = op == 4'h8 ? 1'b1 : op == 4'h9 ? flags[2] : op == 4'ha ? flags[0] :
                  op == 4'hb ? flags[0] | flags[1] : op == 4'hc ? ~flags[0] :
                  op == 4'hd ? ~flags[0] | flags[1] : flags[1];
  always_comb begin
    state_n = state;
    pre_b_n = pre_b;
    pre_op_n = pre_op;
    pre_sel_n = pre_sel;
    alu_op = '0;
    alu_src = '0;
    acc_wr_en = 1'b0;
    reg_wr_en = 1'b0;
    acc_clr = 1'b0;
    reg_clr = 1'b0;
    cmp_load_en = 1'b0;
    lfsr_set_state = 1'b0;
    lfsr_set_tap = 1'b0;
    lfsr_shift = 1'b0;
    mem_addr_sel = 1'b0;
    mem_addr = '0;
    mem_val_sel = 1'b0;
    mem_wr_en = 1'b0;
    imm = '0;
    jump = 1'b0;
    jump_target = '0;
    skip = 1'b0;
    busy = 1'b0;
    ack = 1'b0;
    if (!reset && state == HALT)
      ack = 1'b1;
    else if (!reset && instr_valid)
      case (state)
        REGULAR:
          if (b) begin
            if (op[3] && op != 4'hf) begin
              if (br_hit) begin
                pre_b_n = 1'b1;
                pre_op_n = op;
                pre_sel_n = 1'b0;
                state_n = TARGET;
              end else
                skip = 1'b1;
            end
          end else if (op == 4'h0) begin
            acc_clr = sub == 4'h1;
            reg_clr = sub == 4'h2;
            lfsr_set_state = sub == 4'h3;
            lfsr_set_tap = sub == 4'h4;
            lfsr_shift = sub == 4'h5;
            cmp_load_en = sub == 4'h8;
            mem_wr_en = sub == 4'he;
            mem_val_sel = sub == 4'he;
            ack = sub == 4'hf;
            if (sub[3:1] == 3'b110) begin
              pre_b_n = 1'b0;
              pre_op_n = 4'h0;
              pre_sel_n = ~sub[0];
              state_n = TARGET;
            end
            if (sub == 4'hf) state_n = HALT;
          end else if (m[4]) begin
            if (am == 2'b00) begin
              alu_op = m[2:0];
              acc_wr_en = ~m[3];
              reg_wr_en = m[3];
            end
            if (am == 2'b01 || am == 2'b10) begin
              pre_b_n = 1'b0;
              pre_op_n = op;
              pre_sel_n = 1'b0;
              state_n = am[1] ? IMM : TARGET;
            end
          end
        TARGET: begin
          busy = 1'b1;
          state_n = REGULAR;
          if (pre_b) begin
            jump = 1'b1;
            jump_target = instr[PCW-1:0];
          end else begin
            mem_addr_sel = 1'b1;
            mem_addr = instr[DW-1:0];
            if (pre_op == 4'h0) begin
              mem_wr_en = 1'b1;
              mem_val_sel = pre_sel;
            end else begin
              alu_src = 2'b01;
              alu_op = pm[2:0];
              acc_wr_en = pm[4] & ~pm[3];
              reg_wr_en = pm[4] & pm[3];
            end
          end
        end
        IMM: begin
          busy = 1'b1;
          state_n = REGULAR;
          imm = instr[DW-1:0];
          alu_src = 2'b10;
          alu_op = pm[2:0];
          acc_wr_en = pm[4] & ~pm[3];
          reg_wr_en = pm[4] & pm[3];
        end
        default: ;
      endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= REGULAR;
      pre_b <= 1'b0;
      pre_op <= '0;
      pre_sel <= 1'b0;
    end else begin
      state <= state_n;
      pre_b <= pre_b_n;
      pre_op <= pre_op_n;
      pre_sel <= pre_sel_n;
    end
endmodule

// File: tb/tb_multi_word_ctrl.sv
// tb_multi_word_ctrl: table-driven scoreboard bench for multi_word_ctrl at default and widened parameters
module tb_multi_word_ctrl;
  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] alu_src;
    logic acc_wr_en, reg_wr_en, acc_clr, reg_clr, cmp_load_en;
    logic lfsr_set_state, lfsr_set_tap, lfsr_shift, mem_addr_sel;
    logic [7:0] mem_addr;
    logic mem_val_sel, mem_wr_en;
    logic [7:0] imm;
    logic jump;
    logic [8:0] jump_target;
    logic skip, busy, ack;
  } outs_t;
  typedef struct {
    logic rst;
    logic vld;
    logic [2:0] fl;
    logic [8:0] in;
    outs_t exp;
  } vec_t;
  localparam outs_t Z = '0;
  logic clk = 1'b0;
  logic reset, instr_valid;
  logic [2:0] flags;
  logic [8:0] instr;
  logic [2:0] alu_op;
  logic [1:0] alu_src;
  logic acc_wr_en, reg_wr_en, acc_clr, reg_clr, cmp_load_en;
  logic lfsr_set_state, lfsr_set_tap, lfsr_shift, mem_addr_sel, mem_val_sel, mem_wr_en;
  logic [7:0] mem_addr, imm;
  logic jump, skip, busy, ack;
  logic [8:0] jump_target;
  outs_t act;
  logic [11:0] instr1, jump_target1;
  logic [2:0] alu_op1;
  logic [1:0] alu_src1;
  logic [9:0] mem_addr1, imm1;
  logic acc_wr_en1, reg_wr_en1, acc_clr1, reg_clr1, cmp_load_en1, lfsr_set_state1, lfsr_set_tap1;
  logic lfsr_shift1, mem_addr_sel1, mem_val_sel1, mem_wr_en1, jump1, skip1, busy1, ack1;
  int checks = 0;
  int errors = 0;
  vec_t v[$];
  outs_t sb[$];
  always #5 clk = ~clk;
  multi_word_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .flags(flags),
    .alu_op(alu_op), .alu_src(alu_src), .acc_wr_en(acc_wr_en), .reg_wr_en(reg_wr_en),
    .acc_clr(acc_clr), .reg_clr(reg_clr), .cmp_load_en(cmp_load_en),
    .lfsr_set_state(lfsr_set_state), .lfsr_set_tap(lfsr_set_tap), .lfsr_shift(lfsr_shift),
    .mem_addr_sel(mem_addr_sel), .mem_addr(mem_addr), .mem_val_sel(mem_val_sel),
    .mem_wr_en(mem_wr_en), .imm(imm), .jump(jump), .jump_target(jump_target),
    .skip(skip), .busy(busy), .ack(ack)
  );
  multi_word_ctrl #(.IW(12), .DW(10), .PCW(12)) dut_w (
    .clk(clk), .reset(reset), .instr(instr1), .instr_valid(instr_valid), .flags(flags),
    .alu_op(alu_op1), .alu_src(alu_src1), .acc_wr_en(acc_wr_en1), .reg_wr_en(reg_wr_en1),
    .acc_clr(acc_clr1), .reg_clr(reg_clr1), .cmp_load_en(cmp_load_en1),
    .lfsr_set_state(lfsr_set_state1), .lfsr_set_tap(lfsr_set_tap1), .lfsr_shift(lfsr_shift1),
    .mem_addr_sel(mem_addr_sel1), .mem_addr(mem_addr1), .mem_val_sel(mem_val_sel1),
    .mem_wr_en(mem_wr_en1), .imm(imm1), .jump(jump1), .jump_target(jump_target1),
    .skip(skip1), .busy(busy1), .ack(ack1)
  );
  assign act = {alu_op, alu_src, acc_wr_en, reg_wr_en, acc_clr, reg_clr, cmp_load_en,
                lfsr_set_state, lfsr_set_tap, lfsr_shift, mem_addr_sel, mem_addr,
                mem_val_sel, mem_wr_en, imm, jump, jump_target, skip, busy, ack};
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, a, e);
    end
  endtask
  task automatic add(input logic r, input logic vl, input logic [2:0] f, input logic [8:0] i, input outs_t e);
    vec_t x;
    x.rst = r;
    x.vld = vl;
    x.fl = f;
    x.in = i;
    x.exp = e;
    v.push_back(x);
  endtask
  task automatic step(input vec_t x, input string nm);
    reset = x.rst;
    instr_valid = x.vld;
    flags = x.fl;
    instr = x.in;
    sb.push_back(x.exp);
    @(negedge clk);
    chk(nm, 64'(act), 64'(sb.pop_front()));
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec_t h;
    reset = 1'b1;
    instr_valid = 1'b0;
    flags = '0;
    instr = '0;
    instr1 = '0;
    @(posedge clk);
    #1;
    add(1, 1, 3'b000, 9'b0_0001_00_00, Z);
    add(0, 1, 3'b000, 9'b0_0001_00_00, '{alu_op: 3'd1, acc_wr_en: 1'b1, default: '0});
    add(0, 1, 3'b000, 9'b0_0011_00_00, '{alu_op: 3'd1, reg_wr_en: 1'b1, default: '0});
    add(0, 1, 3'b000, 9'b0_0010_10_00, Z);
    add(0, 1, 3'b000, 9'h005, '{alu_op: 3'd2, alu_src: 2'b10, imm: 8'h05, acc_wr_en: 1'b1, busy: 1'b1, default: '0});
    add(0, 1, 3'b000, 9'b0_0000_0001, '{acc_clr: 1'b1, default: '0});
    add(0, 1, 3'b001, 9'b1_1010_0000, Z);
    add(0, 1, 3'b001, 9'h123, '{jump: 1'b1, jump_target: 9'h123, busy: 1'b1, default: '0});
    add(0, 1, 3'b000, 9'b1_1010_0000, '{skip: 1'b1, default: '0});
    add(0, 1, 3'b000, 9'b0_0000_0010, '{reg_clr: 1'b1, default: '0});
    add(0, 1, 3'b000, 9'b0_0000_1100, Z);
    add(0, 1, 3'b000, 9'h03A, '{mem_wr_en: 1'b1, mem_addr_sel: 1'b1, mem_addr: 8'h3A, mem_val_sel: 1'b1, busy: 1'b1, default: '0});
    add(0, 1, 3'b000, 9'b0_0000_1101, Z);
    add(0, 0, 3'b000, 9'h1FF, Z);
    add(0, 0, 3'b111, 9'h0F1, Z);
    add(0, 0, 3'b000, 9'h100, Z);
    add(0, 1, 3'b000, 9'h03A, '{mem_wr_en: 1'b1, mem_addr_sel: 1'b1, mem_addr: 8'h3A, busy: 1'b1, default: '0});
    add(0, 1, 3'b000, 9'b0_0101_01_00, Z);
    add(0, 1, 3'b000, 9'h0C7, '{alu_op: 3'd3, alu_src: 2'b01, mem_addr_sel: 1'b1, mem_addr: 8'hC7, acc_wr_en: 1'b1, busy: 1'b1, default: '0});
    add(0, 1, 3'b010, 9'b1_1110_0000, Z);
    add(0, 1, 3'b000, 9'h0AA, '{jump: 1'b1, jump_target: 9'h0AA, busy: 1'b1, default: '0});
    add(0, 1, 3'b000, 9'b1_1111_0000, Z);
    add(0, 1, 3'b000, 9'b0_0000_1000, '{cmp_load_en: 1'b1, default: '0});
    add(0, 1, 3'b000, 9'b0_0001_11_00, Z);
    add(0, 1, 3'b000, 9'b0_0000_0011, '{lfsr_set_state: 1'b1, default: '0});
    add(0, 1, 3'b000, 9'b0_1000_10_00, Z);
    add(0, 1, 3'b000, 9'h1F0, '{alu_op: 3'd6, alu_src: 2'b10, imm: 8'hF0, acc_wr_en: 1'b1, busy: 1'b1, default: '0});
    add(0, 1, 3'b000, 9'b0_0010_10_00, Z);
    add(1, 1, 3'b000, 9'h005, Z);
    add(0, 1, 3'b000, 9'h005, '{lfsr_shift: 1'b1, default: '0});
    add(0, 1, 3'b000, 9'b0_0000_1110, '{mem_wr_en: 1'b1, mem_val_sel: 1'b1, default: '0});
    add(0, 1, 3'b000, 9'b0_0000_1111, '{ack: 1'b1, default: '0});
    foreach (v[i]) step(v[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 10; i++) begin
      h.rst = 1'b0;
      h.vld = 1'($urandom);
      h.fl = 3'($urandom);
      h.in = 9'($urandom);
      h.exp = '{ack: 1'b1, default: '0};
      step(h, $sformatf("halt%0d", i));
    end
    h.rst = 1'b1;
    h.vld = 1'b1;
    h.fl = '0;
    h.in = 9'b0_0000_1111;
    h.exp = Z;
    step(h, "halt_reset");
    h.rst = 1'b0;
    h.in = 9'b0_0001_00_00;
    h.exp = '{alu_op: 3'd1, acc_wr_en: 1'b1, default: '0};
    step(h, "after_halt");
    chk("sb_empty", 64'(sb.size()), 64'd0);
    reset = 1'b1;
    instr = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    instr_valid = 1'b1;
    flags = 3'b001;
    instr1 = 12'hD00;
    @(negedge clk);
    chk("w12_prefix", {jump1, skip1, busy1}, 3'b000);
    @(posedge clk);
    #1;
    instr1 = 12'hABC;
    @(negedge clk);
    chk("w12_jump", {jump1, jump_target1, busy1}, {1'b1, 12'hABC, 1'b1});
    @(posedge clk);
    #1;
    flags = 3'b000;
    instr1 = 12'hD00;
    @(negedge clk);
    chk("w12_skip", {jump1, skip1, busy1}, 3'b010);
    @(posedge clk);
    #1;
    instr1 = 12'h000;
    @(negedge clk);
    chk("w12_regular", {jump1, busy1}, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
